// File: rtl/seq_arith_unit.sv
// Sequential signed arithmetic unit: single-cycle add/sub/absdiff and a
// WIDTH-cycle shift-add multiplier, with a valid/ready handshake on both sides.
module seq_arith_unit #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic        [1:0]       sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] Q,
    output logic                    overflow
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state;
    logic        [CW-1:0]   cnt;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   prod_nxt;
    logic signed [PW-1:0]   a_ext;
    logic signed [PW-1:0]   partial;
    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] b_r;
    logic signed [WIDTH:0]  sum;
    logic signed [WIDTH:0]  diff;
    logic signed [WIDTH:0]  absd;
    logic signed [WIDTH-1:0] alu_q;
    logic                   alu_ovf;
    logic                   accept;

    function automatic logic signed [WIDTH:0] ext1(input logic signed [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    // A WIDTH+1-bit signed value fits WIDTH bits iff its top two bits agree.
    function automatic logic wide_ovf(input logic signed [WIDTH:0] v);
        return v[WIDTH] ^ v[WIDTH-1];
    endfunction

    function automatic logic prod_ovf(input logic signed [PW-1:0] p);
        return !((&p[PW-1:WIDTH-1]) || !(|p[PW-1:WIDTH-1]));
    endfunction

    assign accept = in_valid && in_ready;

    always_comb begin
        sum     = ext1(A) + ext1(B);
        diff    = ext1(A) - ext1(B);
        absd    = diff[WIDTH] ? -diff : diff;
        alu_q   = '0;
        alu_ovf = 1'b0;
        case (sel)
            2'b00: begin alu_q = sum[WIDTH-1:0];  alu_ovf = wide_ovf(sum);  end
            2'b01: begin alu_q = diff[WIDTH-1:0]; alu_ovf = wide_ovf(diff); end
            2'b11: begin alu_q = absd[WIDTH-1:0]; alu_ovf = absd[WIDTH] | absd[WIDTH-1]; end
            default: begin alu_q = '0; alu_ovf = 1'b0; end
        endcase
    end

    // The multiplier's MSB carries negative weight, so the last step subtracts.
    always_comb begin
        a_ext    = {{WIDTH{a_r[WIDTH-1]}}, a_r};
        partial  = a_ext <<< cnt;
        prod_nxt = prod;
        if (b_r[cnt])
            prod_nxt = (cnt == LAST) ? prod - partial : prod + partial;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= A;
            b_r <= B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            Q         <= '0;
            overflow  <= 1'b0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (sel == 2'b10) begin
                            state <= CALC;
                            cnt   <= '0;
                            prod  <= '0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            Q         <= alu_q;
                            overflow  <= alu_ovf;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CALC: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Q         <= prod_nxt[WIDTH-1:0];
                        overflow  <= prod_ovf(prod_nxt);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (two's complement).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 A  input  WIDTH  signed operand A.
REQ-008 B  input  WIDTH  signed operand B.
REQ-009 sel  input  2  opcode: 00 add, 01 sub, 10 mul, 11 absdiff.
REQ-010 out_valid  output  1  result presented.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 Q  output  WIDTH  signed result, registered.
REQ-013 overflow  output  1  true result outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], registered.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, CALC, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 An operation is accepted on a rising edge with in_valid=1 and in_ready=1; A, B and sel are captured on that edge, and later input changes do not affect the result.
REQ-017 IDLE transitions: add, sub or absdiff accepted -> DONE, with the result registered on the accept edge (out_valid=1 one cycle after accept); mul accepted -> CALC.
REQ-018 Add/sub SHALL compute at WIDTH+1 bits.
REQ-019 For add/sub, Q = low WIDTH bits (wrap-around), and overflow = 1 iff the WIDTH+1-bit result is out of signed range.
REQ-020 Absdiff SHALL compute |A-B| at WIDTH+1 bits; Q = low WIDTH bits; overflow = 1 iff |A-B| > 2^(WIDTH-1)-1.
REQ-021 Mul SHALL be signed shift-add over exactly WIDTH CALC cycles into a 2*WIDTH-bit product register, so out_valid asserts WIDTH+1 cycles after accept (5 for WIDTH=4).
REQ-022 For mul, Q = low WIDTH bits of the product, and overflow = 1 iff the product is out of WIDTH-bit signed range.
REQ-023 The CALC iteration counter SHALL reset to 0 on entry to CALC; CALC -> DONE when the counter reaches WIDTH-1.
REQ-024 DONE: Q and overflow SHALL be held stable while out_valid=1 and out_ready=0 (backpressure of any length).
REQ-025 DONE -> IDLE on a rising edge with out_ready=1.
REQ-026 in_ready SHALL rise the cycle after the result is consumed; there is no same-cycle result/accept overlap, and an in_valid held across DONE is accepted only after the return to IDLE.
REQ-027 in_valid=0 in IDLE: state and outputs SHALL be unchanged.
REQ-028 Throughput: one add/sub/absdiff per 2 cycles with out_ready tied 1; one mul per WIDTH+2 cycles.

Reset
REQ-029 When rst is asserted, the block SHALL immediately, without waiting for a clock edge, enter IDLE and clear Q=0, overflow=0, out_valid=0, the product register, and the counter.
REQ-030 While rst is asserted, in_ready SHALL be 0.
REQ-031 After rst is released, in_ready SHALL be 1 from the first clock edge onward.
REQ-032 Reset asserted mid-CALC or in DONE SHALL abort the operation; the result is discarded and never presented.

Verification
REQ-033 Add overflow: A=-8, B=-8, sel=00 -> one cycle later out_valid=1, Q=0, overflow=1; A=7, B=-8, sel=00 -> Q=-1, overflow=0.
REQ-034 Sub and absdiff: A=-8, B=1, sel=01 -> Q=7, overflow=1; A=7, B=-8, sel=11 -> Q=-1 (15 wrapped), overflow=1; A=-3, B=2, sel=11 -> Q=5, overflow=0.
REQ-035 Mul latency and range: A=-8, B=-8, sel=10 -> out_valid exactly 5 cycles after accept, Q=0, overflow=1; A=-8, B=1 -> Q=-8, overflow=0; A=3, B=-2 -> Q=-6, overflow=0.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles in DONE while changing A/B/sel/in_valid -> Q/overflow stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-mul: assert rst during the 2nd CALC cycle -> outputs zero immediately and no out_valid appears; a new add accepted after release returns the correct result.
REQ-038 Exhaustive sweep: all A, B in [-8,7] x all four sel values with random out_ready stalls -> every result matches a reference model, with exactly one out_valid handshake per accepted operation.
